// File: rtl/emesh_rr_mux.sv
// Three-way round-robin merge of cmesh/rmesh/xmesh packet streams into a single
// registered emesh output stage with valid/ready handshaking on every side.
module emesh_rr_mux #(
    parameter int AW = 32,
    parameter int PW = 2*AW+40
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cmesh_access_in,
    input  logic [PW-1:0] cmesh_packet_in,
    output logic          cmesh_ready_out,

    input  logic          rmesh_access_in,
    input  logic [PW-1:0] rmesh_packet_in,
    output logic          rmesh_ready_out,

    input  logic          xmesh_access_in,
    input  logic [PW-1:0] xmesh_packet_in,
    output logic          xmesh_ready_out,

    output logic          emesh_access_out,
    output logic [PW-1:0] emesh_packet_out,
    input  logic          emesh_ready_in
);

    // Bit 0 = C, bit 1 = R, bit 2 = X for the request, grant and pointer vectors.
    logic [2:0]    req;
    logic [2:0]    grant;
    logic [2:0]    ptr;
    logic          load_en;
    logic [PW-1:0] sel_packet;

    assign req     = {xmesh_access_in, rmesh_access_in, cmesh_access_in};
    assign load_en = ~emesh_access_out | emesh_ready_in;

    // Scan from the pointer position, wrapping X back to C; nothing is granted
    // while the stage is stalled or the block is in reset.
    always_comb begin
        grant = 3'b000;
        if (load_en && !reset) begin
            case (ptr)
                3'b010: begin
                    if      (req[1]) grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                end
                3'b100: begin
                    if      (req[2]) grant = 3'b100;
                    else if (req[0]) grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                end
                default: begin
                    if      (req[0]) grant = 3'b001;
                    else if (req[1]) grant = 3'b010;
                    else if (req[2]) grant = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        sel_packet = cmesh_packet_in;
        if (grant[1])
            sel_packet = rmesh_packet_in;
        else if (grant[2])
            sel_packet = xmesh_packet_in;
    end

    assign cmesh_ready_out = ~reset & ~(cmesh_access_in & ~grant[0]);
    assign rmesh_ready_out = ~reset & ~(rmesh_access_in & ~grant[1]);
    assign xmesh_ready_out = ~reset & ~(xmesh_access_in & ~grant[2]);

    // Rotating the grant left hands top priority to the input after the winner.
    always_ff @(posedge clk) begin
        if (reset) begin
            emesh_access_out <= 1'b0;
            emesh_packet_out <= '0;
            ptr              <= 3'b001;
        end else if (load_en) begin
            emesh_access_out <= |grant;
            if (|grant) begin
                emesh_packet_out <= sel_packet;
                ptr              <= {grant[1:0], grant[2]};
            end
        end
    end

endmodule

// File: tb/tb_emesh_rr_mux.sv
// Directed scenarios followed by random traffic, all checked against an
// index-based round-robin reference model of the merge.
module tb_emesh_rr_mux;

    localparam int AW = 32;
    localparam int PW = 2*AW+40;

    logic          clk;
    logic          reset;
    logic [2:0]    acc;
    logic [PW-1:0] pk [3];
    logic          emesh_ready_in;
    logic [2:0]    rdy;
    logic          emesh_access_out;
    logic [PW-1:0] emesh_packet_out;

    int checks = 0;
    int errors = 0;

    int            m_ptr;
    logic          m_valid;
    logic [PW-1:0] m_pkt;
    int            m_grant;
    logic [2:0]    m_rdy;

    logic [3:0] tags [3] = '{4'hC, 4'hA, 4'hB};

    emesh_rr_mux #(.AW(AW), .PW(PW)) dut (
        .clk              (clk),
        .reset            (reset),
        .cmesh_access_in  (acc[0]),
        .cmesh_packet_in  (pk[0]),
        .cmesh_ready_out  (rdy[0]),
        .rmesh_access_in  (acc[1]),
        .rmesh_packet_in  (pk[1]),
        .rmesh_ready_out  (rdy[1]),
        .xmesh_access_in  (acc[2]),
        .xmesh_packet_in  (pk[2]),
        .xmesh_ready_out  (rdy[2]),
        .emesh_access_out (emesh_access_out),
        .emesh_packet_out (emesh_packet_out),
        .emesh_ready_in   (emesh_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [PW-1:0] gen(input logic [3:0] tag);
        logic [127:0]  r;
        logic [PW-1:0] p;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        p = r[PW-1:0];
        p[PW-1:PW-4] = tag;
        return p;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: ready is checked mid-cycle, the output stage after the edge,
    // and a granted input then offers a fresh packet.
    task automatic applyStimulus();
        bit load;
        load    = !m_valid || emesh_ready_in;
        m_grant = -1;
        if (!reset && load) begin
            for (int k = 0; k < 3; k++) begin
                if (m_grant < 0 && acc[(m_ptr + k) % 3]) m_grant = (m_ptr + k) % 3;
            end
        end
        for (int j = 0; j < 3; j++)
            m_rdy[j] = !reset && !(acc[j] && (m_grant != j));

        @(negedge clk);
        check("cmesh_ready_out", 128'(rdy[0]), 128'(m_rdy[0]));
        check("rmesh_ready_out", 128'(rdy[1]), 128'(m_rdy[1]));
        check("xmesh_ready_out", 128'(rdy[2]), 128'(m_rdy[2]));

        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_pkt   = '0;
            m_ptr   = 0;
        end else if (load) begin
            m_valid = (m_grant >= 0);
            if (m_grant >= 0) begin
                m_pkt = pk[m_grant];
                m_ptr = (m_grant + 1) % 3;
            end
        end
        #1;
        check("emesh_access_out", 128'(emesh_access_out), 128'(m_valid));
        check("emesh_packet_out", 128'(emesh_packet_out), 128'(m_pkt));
        if (m_grant >= 0) pk[m_grant] = gen(tags[m_grant]);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] exp_tag);
        check(tag, 128'(emesh_packet_out[PW-1:PW-4]), 128'(exp_tag));
    endtask

    initial begin
        logic [3:0]    seq [6];
        logic [PW-1:0] held;
        seq = '{4'hC, 4'hA, 4'hB, 4'hC, 4'hA, 4'hB};
        m_ptr   = 0;
        m_valid = 1'b0;
        m_pkt   = '0;
        reset   = 1'b1;
        acc     = 3'b000;
        emesh_ready_in = 1'b1;
        for (int j = 0; j < 3; j++) pk[j] = gen(tags[j]);

        applyStimulus();
        applyStimulus();
        reset = 1'b0;

        // All three request constantly with the sink always ready.
        acc = 3'b111;
        for (int i = 0; i < 6; i++) begin
            applyStimulus();
            checkOutput("rr_order", seq[i]);
            check("rr_valid", 128'(emesh_access_out), 128'(1'b1));
        end

        // Stage full and stalled while C and X wait; R idle stays ready.
        acc  = 3'b101;
        emesh_ready_in = 1'b0;
        held = emesh_packet_out;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            check("stall_hold", 128'(emesh_packet_out), 128'(held));
            check("stall_rready", 128'(rdy[1]), 128'(1'b1));
        end
        emesh_ready_in = 1'b1;
        applyStimulus();
        checkOutput("stall_ptr_c", 4'hC);
        applyStimulus();
        checkOutput("stall_ptr_x", 4'hB);

        // Lone persistent R requester streams back to back.
        acc = 3'b010;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("r_stream", 4'hA);
            check("r_stream_valid", 128'(emesh_access_out), 128'(1'b1));
        end

        // One-cycle reset with a full stage, then X and C contend.
        acc   = 3'b000;
        reset = 1'b1;
        applyStimulus();
        check("rst_valid", 128'(emesh_access_out), 128'(1'b0));
        check("rst_packet", 128'(emesh_packet_out), 128'(0));
        reset = 1'b0;
        acc   = 3'b101;
        applyStimulus();
        checkOutput("rst_first_c", 4'hC);

        // X wins, idle three cycles, then C and R: pointer wrapped to C.
        acc = 3'b100;
        applyStimulus();
        checkOutput("wrap_x", 4'hB);
        acc = 3'b000;
        for (int i = 0; i < 3; i++) applyStimulus();
        acc = 3'b011;
        applyStimulus();
        checkOutput("wrap_c", 4'hC);

        // Empty stage accepts C even with the sink stalled, then holds.
        acc = 3'b000;
        applyStimulus();
        emesh_ready_in = 1'b0;
        acc = 3'b001;
        applyStimulus();
        checkOutput("empty_load", 4'hC);
        acc = 3'b000;
        applyStimulus();
        applyStimulus();
        check("empty_hold", 128'(emesh_access_out), 128'(1'b1));
        emesh_ready_in = 1'b1;
        applyStimulus();
        check("empty_drain", 128'(emesh_access_out), 128'(1'b0));

        // Random traffic with occasional reset pulses.
        for (int i = 0; i < 300; i++) begin
            acc            = 3'($urandom_range(0, 7));
            emesh_ready_in = 1'($urandom_range(0, 3) != 0);
            reset          = ($urandom_range(0, 31) == 0);
            applyStimulus();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
